// File: rtl/video_pkg.sv
// Shared video-pipeline types: RGB pixel struct, stage FSM states, header decode.
package video_pkg;

  localparam int unsigned CH_W = 8;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  typedef enum logic [2:0] {IDLE, PASS, FILL, STREAM, FLUSH} state_t;

  // A packet whose header has a zero blue low nibble carries video pixels.
  function automatic logic is_video_hdr(input logic [3*CH_W-1:0] data);
    return data[3:0] == 4'h0;
  endfunction

endpackage

// File: rtl/rgb_tap3.sv
// Combinational [1 2 1]/4 filter applied independently to each colour channel.
module rgb_tap3
  import video_pkg::*;
(
  input  rgb_t a,
  input  rgb_t b,
  input  rgb_t c,
  output rgb_t y
);

  // Two extra bits hold the worst case 4*255, so truncation never overflows.
  function automatic logic [CH_W-1:0] tap(input logic [CH_W-1:0] l,
                                          input logic [CH_W-1:0] m,
                                          input logic [CH_W-1:0] r);
    logic [CH_W+1:0] s;
    s = {2'b00, l} + {1'b0, m, 1'b0} + {2'b00, r};
    return s[CH_W+1:2];
  endfunction

  // Per-channel filter.
  always_comb begin
    y.r = tap(a.r, b.r, c.r);
    y.g = tap(a.g, b.g, c.g);
    y.b = tap(a.b, b.b, c.b);
  end

endmodule

// File: rtl/video_hsmooth.sv
// Horizontal 3-tap smoothing stage for the RGB Avalon-ST video stream.
// Edge pixels are replicated; control packets and bypassed frames pass unchanged.
module video_hsmooth
  import video_pkg::*;
#(
  parameter int unsigned IMAGE_W = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        mode
);

  localparam int unsigned XW = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
  localparam logic [XW-1:0] XLast = XW'(IMAGE_W - 1);

  state_t      state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  rgb_t        prev_q, prev_d, cur_q, cur_d;
  logic        cur_eop_q, cur_eop_d;
  logic [23:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;

  logic        adv, pend_flush, acc, x_last, line_end;
  logic [XW-1:0] x_inc;
  rgb_t        tap_c, tap_y;

  // Right tap is the incoming pixel while streaming, otherwise the replicated held pixel.
  assign tap_c = (state_q == STREAM && !pend_flush) ? rgb_t'(sink_data) : cur_q;

  rgb_tap3 u_tap (
    .a (prev_q),
    .b (cur_q),
    .c (tap_c),
    .y (tap_y)
  );

  // Handshake and line-position decode.
  always_comb begin
    adv        = !out_valid_q | source_ready;
    // A new sop while a pixel is held must first flush that pixel.
    pend_flush = sink_valid & sink_sop & (state_q == STREAM);
    sink_ready = !reset & adv & (state_q != FLUSH) & !pend_flush;
    acc        = sink_valid & sink_ready;
    x_last     = (x_q == XLast);
    x_inc      = x_last ? '0 : x_q + XW'(1);
    line_end   = sink_eop | x_last;
  end

  // Next-state, window and output-register logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    cur_eop_d   = cur_eop_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    if (adv) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
    end
    if (acc && sink_sop) begin
      out_valid_d = 1'b1;
      out_data_d  = sink_data;
      out_sop_d   = 1'b1;
      out_eop_d   = sink_eop;
      x_d         = '0;
      if (sink_eop)                              state_d = IDLE;
      else if (is_video_hdr(sink_data) && mode)  state_d = FILL;
      else                                       state_d = PASS;
    end else if (acc) begin
      case (state_q)
        PASS: begin
          out_valid_d = 1'b1;
          out_data_d  = sink_data;
          out_eop_d   = sink_eop;
          if (sink_eop) state_d = IDLE;
        end
        FILL: begin
          prev_d    = rgb_t'(sink_data);
          cur_d     = rgb_t'(sink_data);
          cur_eop_d = sink_eop;
          x_d       = x_inc;
          state_d   = line_end ? FLUSH : STREAM;
        end
        STREAM: begin
          out_valid_d = 1'b1;
          out_data_d  = tap_y;
          prev_d      = cur_q;
          cur_d       = rgb_t'(sink_data);
          cur_eop_d   = sink_eop;
          x_d         = x_inc;
          if (line_end) state_d = FLUSH;
        end
        default: ;  // IDLE drops stray words outside a packet
      endcase
    end else if (adv && (state_q == FLUSH || pend_flush)) begin
      out_valid_d = 1'b1;
      out_data_d  = tap_y;
      out_eop_d   = (state_q == FLUSH) & cur_eop_q;
      state_d     = ((state_q == FLUSH) && cur_eop_q) ? IDLE : FILL;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      cur_eop_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      cur_eop_q   <= cur_eop_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign source_data  = out_data_q;
  assign source_valid = out_valid_q;
  assign source_sop   = out_sop_q;
  assign source_eop   = out_eop_q;

endmodule

// File: tb/tb_video_hsmooth.sv
// Self-checking bench for video_hsmooth: line tables, hand sequences, scoreboard.
module tb_video_hsmooth;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [23:0] d;
    logic        sop;
    logic        eop;
  } obs_t;

  typedef struct packed {
    logic [31:0] in_r;
    logic [31:0] exp_r;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic        sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop;
  logic        source_ready = 1'b1;
  logic        mode = 1'b1;

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, sop_cyc = 0, eop_cyc = 0, win_cnt = 0, sop_seen = 0, eop_seen = 0;
  bit   mon_chk = 1'b1, bp_en = 1'b0;
  obs_t exp_q[$];
  obs_t e;
  logic [23:0] pix [0:63];
  vec_t tbl [5];

  video_hsmooth #(.IMAGE_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Independent reference for one output pixel.
  function automatic logic [23:0] ref_f(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] c);
    logic [23:0] r;
    for (int k = 0; k < 3; k++) begin
      int s;
      s = int'(a[8*k +: 8]) + 2 * int'(b[8*k +: 8]) + int'(c[8*k +: 8]);
      r[8*k +: 8] = 8'(s / 4);
    end
    return r;
  endfunction

  // Output monitor: pops and compares one expectation per handshake.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset && mon_chk && source_valid && source_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h sop=%0b eop=%0b required none",
                 source_data, source_sop, source_eop);
      end else begin
        e = exp_q.pop_front();
        chk("out_word", {6'b0, source_data, source_sop, source_eop}, {6'b0, e.d, e.sop, e.eop});
      end
      if (source_sop) begin
        sop_seen++;
        sop_cyc = cyc;
        win_cnt = 0;
      end
      win_cnt++;
      if (source_eop) begin
        eop_seen++;
        eop_cyc = cyc;
      end
    end
  end

  // Downstream ready: always 1 or 50% random.
  initial forever begin
    @(posedge clk);
    #1;
    source_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_word(input logic [23:0] d, input logic s, input logic eo);
    int t = 0;
    bit done = 1'b0;
    sink_data  = d;
    sink_sop   = s;
    sink_eop   = eo;
    sink_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (sink_ready) done = 1'b1;
      else if (++t > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got sink_ready=0 for %0d cycles required 1", t);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    sink_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d outputs outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_model(input int n, input bit filt, input bit trunc);
    for (int i = 0; i < n; i++) begin
      int ls, le, l, r;
      obs_t o;
      ls = (i / W) * W;
      le = (ls + W < n) ? ls + W - 1 : n - 1;
      l  = (i == ls) ? i : i - 1;
      r  = (i == le) ? i : i + 1;
      o.d   = filt ? ref_f(pix[l], pix[i], pix[r]) : pix[i];
      o.sop = 1'b0;
      o.eop = (i == n - 1) && !trunc;
      exp_q.push_back(o);
    end
  endtask

  task automatic send_frame(input logic [23:0] hdr, input int n, input logic m, input bit filt,
                            input bit trunc, input bit rnd);
    mode = m;
    exp_q.push_back('{d: hdr, sop: 1'b1, eop: 1'b0});
    push_model(n, filt, trunc);
    send_word(hdr, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        mode = 1'($urandom_range(0, 1));
      end
      send_word(pix[i], 1'b0, (i == n - 1) && !trunc);
    end
  endtask

  // Back-to-back words with a latency-1, no-bubble check on every word.
  task automatic send_lat(input logic [23:0] hdr, input int n, input logic m);
    logic [23:0] w, pw;
    pw = '0;
    mode = m;
    for (int i = 0; i <= n; i++) begin
      w = (i == 0) ? hdr : pix[i-1];
      exp_q.push_back('{d: w, sop: (i == 0), eop: (i == n)});
      sink_data  = w;
      sink_sop   = (i == 0);
      sink_eop   = (i == n);
      sink_valid = 1'b1;
      @(negedge clk);
      chk("lat_ready", {31'b0, sink_ready}, 32'd1);
      if (i > 0) chk("lat_data", {7'b0, source_valid, source_data}, {7'b0, 1'b1, pw});
      @(posedge clk);
      #1;
      pw = w;
    end
    sink_valid = 1'b0;
    @(negedge clk);
    chk("lat_data", {7'b0, source_valid, source_data}, {7'b0, 1'b1, pw});
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  initial begin
    int s0, e0;
    tbl[0] = '{in_r: 32'h0000FF00, exp_r: 32'h003F7F3F};  // impulse
    tbl[1] = '{in_r: 32'hFF000000, exp_r: 32'hBF3F0000};  // left-edge replication
    tbl[2] = '{in_r: 32'h00285078, exp_r: 32'h0A28506E};  // ramp
    tbl[3] = '{in_r: 32'h01020304, exp_r: 32'h01020303};  // truncation of the sum
    tbl[4] = '{in_r: 32'hFFFFFFFF, exp_r: 32'hFFFFFFFF};  // full-scale, no overflow

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, source_valid}, 32'd0);
    chk("rst_sop_eop", {30'b0, source_sop, source_eop}, 32'd0);
    chk("rst_data", {8'b0, source_data}, 32'd0);
    chk("rst_ready", {31'b0, sink_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, sink_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Flat frame: two lines of a constant colour, two bubbles.
    for (int i = 0; i < 8; i++) pix[i] = 24'h804020;
    mode = 1'b1;
    exp_q.push_back('{d: 24'h000000, sop: 1'b1, eop: 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back('{d: 24'h804020, sop: 1'b0, eop: (i == 7)});
    send_word(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_word(pix[i], 1'b0, i == 7);
    wait_drain();
    chk("flat_bubbles", 32'(eop_cyc - sop_cyc + 1 - win_cnt), 32'd2);

    // Single-line table vectors.
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back('{d: 24'h000000, sop: 1'b1, eop: 1'b0});
      for (int k = 0; k < 4; k++) begin
        pix[k] = {tbl[v].in_r[31-8*k -: 8], 8'h40, 8'h20};
        exp_q.push_back('{d: {tbl[v].exp_r[31-8*k -: 8], 8'h40, 8'h20}, sop: 1'b0,
                          eop: (k == 3)});
      end
      send_word(24'h000000, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) send_word(pix[k], 1'b0, k == 3);
      wait_drain();
    end

    // Control packet and bypassed video frame: bit-identical, latency 1, no bubble.
    pix[0] = 24'h123456; pix[1] = 24'hABCDEF; pix[2] = 24'h00FF00;
    send_lat(24'hABCD0F, 3, 1'b1);
    for (int i = 0; i < 6; i++) pix[i] = 24'($urandom);
    send_lat(24'h000000, 6, 1'b0);

    // Random backpressure over two frames, mode toggling mid-frame.
    bp_en = 1'b1;
    s0 = sop_seen;
    e0 = eop_seen;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 24; i++) pix[i] = 24'($urandom);
      send_frame(24'h000000, 24, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    wait_drain();
    bp_en = 1'b0;
    chk("bp_sop_count", 32'(sop_seen - s0), 32'd2);
    chk("bp_eop_count", 32'(eop_seen - e0), 32'd2);

    // Truncated frame: sop after 5 pixels (one full line plus one held pixel).
    for (int i = 0; i < 5; i++) pix[i] = 24'($urandom);
    send_frame(24'h000000, 5, 1'b1, 1'b1, 1'b1, 1'b0);
    pix[0] = 24'h111111; pix[1] = 24'h222222;
    send_frame(24'h00000F, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Reset mid-line: nothing stale may appear afterwards.
    mon_chk = 1'b0;
    for (int i = 0; i < 3; i++) pix[i] = 24'($urandom);
    mode = 1'b1;
    send_word(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_word(pix[i], 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'b0, sink_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mon_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_valid", {31'b0, source_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) pix[i] = 24'($urandom);
    send_frame(24'h000000, 8, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_hsmooth.md
# video_hsmooth

Horizontal 3-tap [1 2 1]/4 smoothing stage on the 24-bit RGB Avalon-ST video stream. It sits directly upstream of the colour-detection / bounding-box stage and feeds it pre-filtered frames, so isolated noisy pixels no longer trigger red detection. Control packets and every start-of-packet word pass through unmodified. A `mode` conduit bypasses filtering; a bypassed stage is a pure one-register pipeline.

## Interface
- `IMAGE_W`, 640: pixels per line; the x counter wraps at `IMAGE_W-1`.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `sink_data` in 24: RGB pixel `{R[23:16],G[15:8],B[7:0]}`.
- `sink_valid` in 1: input word valid.
- `sink_ready` out 1: stage accepts the word this cycle.
- `sink_sop` / `sink_eop` in 1: packet delimiters.
- `source_data` out 24: filtered or passed word.
- `source_valid` out 1 / `source_ready` in 1 / `source_sop` out 1 / `source_eop` out 1: downstream Avalon-ST, ready latency 0.
- `mode` in 1: 1 = filter, 0 = bypass. Sampled only on an accepted sop word.

## Operation
- Accept = `sink_valid & sink_ready`. Emit = `source_valid & source_ready`.
- Sop word: forwarded unchanged. Latch `video = (sink_data[3:0]==0)` and `filt = video & mode`. Clear x. Enter PASS if `!filt`, else FILL.
- States:
  - **PASS**: each accepted word forwarded unchanged. Eop returns the stage to idle (waiting for the next sop).
  - **FILL**: holds pixel x=0 as `cur`, with `prev=cur`. The next accept goes to STREAM.
  - **STREAM**: on accepting `nxt`, emit `f(prev,cur,nxt)`, then shift `prev<=cur`, `cur<=nxt`.
  - **FLUSH**: `sink_ready=0`. Emit `f(prev,cur,cur)`, then return to FILL, or go idle if the held pixel carried eop.
- Transitions out of STREAM:
  - Accepted pixel has x==`IMAGE_W-1` or carries eop: emit as above, then go to FLUSH.
  - A line of length 1 (eop in FILL): go directly to FLUSH with `prev=cur`.
- Filter per channel: `(a + 2b + c) >> 2`. Use a 10-bit sum and truncate. Maximum 255*4=1020, so the result always fits 8 bits with no saturation.
- source_eop is asserted only on the output pixel derived from the input word that carried eop. source_sop is asserted only on the forwarded sop word.
- A sop arriving mid-frame (truncated frame):
  - Any held pixel is first flushed without eop.
  - The sop is then accepted (sink_ready=0 for one cycle).
  - Downstream sees exactly one output per input word.
- Reset: state idle, x=0, source_valid=0, source_sop=0, source_eop=0, source_data=0, sink_ready=0 during reset and 1 on the first cycle after.

## Timing
- Output register: the source signals are flops and are held stable while `source_valid & !source_ready`.
- `sink_ready = (!source_valid | source_ready) & state!=FLUSH & !pending_sop_flush`.
- Latency:
  - Bypass/PASS: 1 cycle.
  - Filter: first output of a line one accept after pixel 1 is accepted.
  - Last pixel of a line: one cycle after pixel `IMAGE_W-1`.
- Throughput: 1 word/cycle, minus one bubble per line (FLUSH). 640×480 costs 480 extra cycles per frame.
- Backpressure: any stall freezes state, window registers and x. No word is dropped or duplicated.
- `mode` toggling mid-frame has no effect until the next sop.

## Structure
- Package `video_pkg`, shared with the detection stage:
  - `rgb_t` struct (three 8-bit channels).
  - State enum `{IDLE, PASS, FILL, STREAM, FLUSH}`.
  - `CH_W=8`.
  - Helper `is_video_hdr(data)`.
- Sub-module `rgb_tap3`: purely combinational per-pixel filter, instantiated once, taking three `rgb_t` and returning one `rgb_t`.
- Top module: FSM, x counter, window registers, output register.

## Test plan
- Flat frame: `IMAGE_W=4`, mode=1, header 0x000000 then 8 pixels all 0x804020, source_ready=1.
  - Expect the header unchanged, then 8 outputs all 0x804020.
  - Expect eop on the 8th output and 2 bubbles in total.
- Impulse: line R = 0,0,255,0 → output R = 0,63,127,63.
  - Edge replication check: line R = 255,0,0,0 → 191,63,0,0.
- Control packet: header blue nibble 0xF plus 3 words.
  - Expect all words bit-identical with latency 1 and no FLUSH bubble.
  - Repeat with mode=0 on a video frame: identical output.
- Random backpressure: source_ready 50% random over two 640×480 frames.
  - Output must match the reference-model filtered stream word for word.
  - Expect exactly one sop and one eop per frame.
- Truncated frame: sop arriving after 5 pixels of a line.
  - Expect 5 filtered outputs, the last using right-edge replication and without eop, then the new sop forwarded.
  - Reset asserted mid-line: the next cycle shows source_valid=0 and no stale pixel is emitted afterwards.
